// File: rtl/id_stage_pipe.sv
// Decode stage with integrated ID/EX pipeline register, load-use bubble insertion and EX stall/flush.
// Optional build macro ID_RF_BYPASS_EN: register file reads see a same-cycle WB write (write-through).
module id_stage_pipe #(
    parameter  int XLEN    = 32,
    parameter  int REG_NUM = 32,
    localparam int AW      = $clog2(REG_NUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            ex_stall,
    input  logic            ex_flush,
    input  logic            wb_regwrite,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_wd,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [AW-1:0]   ex_rs1,
    output logic [AW-1:0]   ex_rs2,
    output logic [AW-1:0]   ex_rd,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [XLEN-1:0] ex_imm,
    output logic [16:0]     ex_ctrl
);

    localparam int CTRL_MEMREAD = 14;

    localparam logic [4:0] ALU_NOP  = 5'd0,  ALU_LUI  = 5'd1,  ALU_AUIPC = 5'd2,  ALU_ADD  = 5'd3;
    localparam logic [4:0] ALU_SUB  = 5'd4,  ALU_SLL  = 5'd5,  ALU_SLT   = 5'd6,  ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_XOR  = 5'd8,  ALU_SRL  = 5'd9,  ALU_SRA   = 5'd10, ALU_OR   = 5'd11;
    localparam logic [4:0] ALU_AND  = 5'd12, ALU_BEQ  = 5'd13, ALU_BNE   = 5'd14, ALU_BLT  = 5'd15;
    localparam logic [4:0] ALU_BGE  = 5'd16, ALU_BLTU = 5'd17, ALU_BGEU  = 5'd18;

    localparam logic [1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC = 2'd2;
    localparam logic [2:0] NPC_PLUS4 = 3'b000, NPC_BRANCH = 3'b001, NPC_JAL = 3'b010, NPC_JALR = 3'b100;
    localparam logic [2:0] DM_WORD = 3'd0, DM_HALF = 3'd1, DM_HALFU = 3'd2, DM_BYTE = 3'd3, DM_BYTEU = 3'd4;

    typedef enum logic [2:0] {
        EXT_NONE, EXT_I, EXT_S, EXT_B, EXT_U, EXT_J, EXT_SHAMT
    } ext_op_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
    } idex_t;

    logic [XLEN-1:0] rf_q [REG_NUM];

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic            f7b5_s;
    logic [AW-1:0]   rs1_s, rs2_s, rd_s;
    logic [XLEN-1:0] rd1_s, rd2_s, imm_s;
    logic [31:0]     imm32_s;
    ext_op_e         ext_op_s;
    logic            rw_s, mw_s, mr_s, alu_src_s;
    logic [4:0]      alu_op_s;
    logic [1:0]      wd_sel_s;
    logic [2:0]      npc_op_s, dm_type_s;
    logic [16:0]     ctrl_s;
    logic            luh_s;

    logic            ex_valid_q, ex_valid_d;
    logic [16:0]     ex_ctrl_q, ex_ctrl_d;
    idex_t           idex_q, idex_d, dec_s;

    assign opcode_s = if_inst[6:0];
    assign funct3_s = if_inst[14:12];
    assign f7b5_s   = if_inst[30];
    assign rs1_s    = AW'(if_inst[19:15]);
    assign rs2_s    = AW'(if_inst[24:20]);
    assign rd_s     = AW'(if_inst[11:7]);

    // Main control decode and immediate-format selection
    always_comb begin
        rw_s      = 1'b0;
        mw_s      = 1'b0;
        mr_s      = 1'b0;
        alu_op_s  = ALU_NOP;
        wd_sel_s  = WD_ALU;
        npc_op_s  = NPC_PLUS4;
        alu_src_s = 1'b0;
        dm_type_s = DM_WORD;
        ext_op_s  = EXT_NONE;
        case (opcode_s)
            7'b0110111: begin rw_s = 1'b1; alu_op_s = ALU_LUI;   alu_src_s = 1'b1; ext_op_s = EXT_U; end
            7'b0010111: begin rw_s = 1'b1; alu_op_s = ALU_AUIPC; alu_src_s = 1'b1; ext_op_s = EXT_U; end
            7'b1101111: begin rw_s = 1'b1; wd_sel_s = WD_PC; npc_op_s = NPC_JAL; ext_op_s = EXT_J; end
            7'b1100111: begin
                rw_s = 1'b1; wd_sel_s = WD_PC; npc_op_s = NPC_JALR;
                alu_op_s = ALU_ADD; alu_src_s = 1'b1; ext_op_s = EXT_I;
            end
            7'b1100011: begin
                npc_op_s = NPC_BRANCH;
                ext_op_s = EXT_B;
                case (funct3_s)
                    3'b000:  alu_op_s = ALU_BEQ;
                    3'b001:  alu_op_s = ALU_BNE;
                    3'b100:  alu_op_s = ALU_BLT;
                    3'b101:  alu_op_s = ALU_BGE;
                    3'b110:  alu_op_s = ALU_BLTU;
                    3'b111:  alu_op_s = ALU_BGEU;
                    default: alu_op_s = ALU_NOP;
                endcase
            end
            7'b0000011: begin
                rw_s = 1'b1; mr_s = 1'b1; wd_sel_s = WD_MEM;
                alu_op_s = ALU_ADD; alu_src_s = 1'b1; ext_op_s = EXT_I;
                case (funct3_s)
                    3'b000:  dm_type_s = DM_BYTE;
                    3'b001:  dm_type_s = DM_HALF;
                    3'b100:  dm_type_s = DM_BYTEU;
                    3'b101:  dm_type_s = DM_HALFU;
                    default: dm_type_s = DM_WORD;
                endcase
            end
            7'b0100011: begin
                mw_s = 1'b1; alu_op_s = ALU_ADD; alu_src_s = 1'b1; ext_op_s = EXT_S;
                case (funct3_s)
                    3'b000:  dm_type_s = DM_BYTE;
                    3'b001:  dm_type_s = DM_HALF;
                    default: dm_type_s = DM_WORD;
                endcase
            end
            7'b0010011, 7'b0110011: begin
                rw_s      = 1'b1;
                alu_src_s = opcode_s[5] ? 1'b0 : 1'b1;
                if (opcode_s[5]) begin
                    ext_op_s = EXT_NONE;
                end else if (funct3_s == 3'b001 || funct3_s == 3'b101) begin
                    ext_op_s = EXT_SHAMT;
                end else begin
                    ext_op_s = EXT_I;
                end
                // funct7[5] selects SUB only for register-register; SRA for both forms
                case (funct3_s)
                    3'b000:  alu_op_s = (opcode_s[5] && f7b5_s) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op_s = ALU_SLL;
                    3'b010:  alu_op_s = ALU_SLT;
                    3'b011:  alu_op_s = ALU_SLTU;
                    3'b100:  alu_op_s = ALU_XOR;
                    3'b101:  alu_op_s = f7b5_s ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op_s = ALU_OR;
                    default: alu_op_s = ALU_AND;
                endcase
            end
            default: begin
                rw_s = 1'b0;
            end
        endcase
    end

    assign ctrl_s = {rw_s, mw_s, mr_s, alu_op_s, wd_sel_s, npc_op_s, alu_src_s, dm_type_s};

    // Immediate assembly; all formats are built at 32 bits then sign-extended to XLEN
    always_comb begin
        imm32_s = 32'd0;
        case (ext_op_s)
            EXT_I:     imm32_s = {{20{if_inst[31]}}, if_inst[31:20]};
            EXT_S:     imm32_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
            EXT_B:     imm32_s = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
            EXT_U:     imm32_s = {if_inst[31:12], 12'd0};
            EXT_J:     imm32_s = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
            EXT_SHAMT: imm32_s = {27'd0, if_inst[24:20]};
            default:   imm32_s = 32'd0;
        endcase
        imm_s = XLEN'(signed'(imm32_s));
    end

    // Register file read ports, x0 hard-wired to zero
    always_comb begin
        rd1_s = '0;
        rd2_s = '0;
        if (rs1_s != '0) begin
            rd1_s = rf_q[rs1_s];
        end else begin
            rd1_s = '0;
        end
        if (rs2_s != '0) begin
            rd2_s = rf_q[rs2_s];
        end else begin
            rd2_s = '0;
        end
`ifdef ID_RF_BYPASS_EN
        if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs1_s)) begin
            rd1_s = wb_wd;
        end else begin
            rd1_s = rd1_s;
        end
        if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs2_s)) begin
            rd2_s = wb_wd;
        end else begin
            rd2_s = rd2_s;
        end
`endif
    end

    // Register file write port; x0 is never written
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_regwrite && (wb_rd != '0)) begin
            rf_q[wb_rd] <= wb_wd;
        end
    end

    assign dec_s = '{pc: if_pc, rs1: rs1_s, rs2: rs2_s, rd: rd_s, rd1: rd1_s, rd2: rd2_s, imm: imm_s};

    // rs2 is compared for every opcode; the occasional needless stall is accepted
    assign luh_s = if_valid && ex_valid_q && ex_ctrl_q[CTRL_MEMREAD] && (ex_rd_q_s() != '0) &&
                   ((ex_rd_q_s() == rs1_s) || (ex_rd_q_s() == rs2_s));

    function automatic logic [AW-1:0] ex_rd_q_s();
        return idex_q.rd;
    endfunction

    // ID/EX next-state: flush > stall > load-use bubble > normal advance
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        idex_d     = idex_q;
        id_ready   = 1'b1;
        if (ex_flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = 17'd0;
            id_ready   = 1'b1;
        end else if (ex_stall) begin
            id_ready   = 1'b0;
        end else if (luh_s) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = 17'd0;
            id_ready   = 1'b0;
        end else begin
            ex_valid_d = if_valid;
            ex_ctrl_d  = if_valid ? ctrl_s : 17'd0;
            idex_d     = dec_s;
            id_ready   = 1'b1;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= 17'd0;
            idex_q     <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            idex_q     <= idex_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_ctrl  = ex_ctrl_q;
    assign ex_pc    = idex_q.pc;
    assign ex_rs1   = idex_q.rs1;
    assign ex_rs2   = idex_q.rs2;
    assign ex_rd    = idex_q.rd;
    assign ex_rd1   = idex_q.rd1;
    assign ex_rd2   = idex_q.rd2;
    assign ex_imm   = idex_q.imm;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: vector table through a one-deep scoreboard plus
// hand-built stall/flush/reset sequences.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_inst, if_pc;
    logic        id_ready, ex_stall, ex_flush, wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [16:0] ex_ctrl;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .REG_NUM(32)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready), .ex_stall(ex_stall), .ex_flush(ex_flush),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl)
    );

`ifdef ID_RF_BYPASS_EN
    localparam logic [31:0] BYP_X9 = 32'h0000CAFE;
`else
    localparam logic [31:0] BYP_X9 = 32'h00000000;
`endif

    typedef struct {
        logic        v;
        logic [31:0] inst, pc;
        logic        stall, flush, we;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic        e_rdy, e_val, chk;
        logic [31:0] e_pc;
        logic [4:0]  e_rs1, e_rs2, e_rd;
        logic [31:0] e_rd1, e_rd2, e_imm;
        logic [16:0] e_ctrl;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t iv(input logic [31:0] inst, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] imm, input logic [16:0] ctrl);
        vec_t x;
        x.v = 1'b1; x.inst = inst; x.pc = 32'h0; x.stall = 1'b0; x.flush = 1'b0;
        x.we = 1'b0; x.wrd = 5'd0; x.wd = 32'h0;
        x.e_rdy = 1'b1; x.e_val = 1'b1; x.chk = 1'b1; x.e_pc = 32'h0;
        x.e_rs1 = r1; x.e_rs2 = r2; x.e_rd = rd; x.e_rd1 = d1; x.e_rd2 = d2; x.e_imm = imm; x.e_ctrl = ctrl;
        return x;
    endfunction

    function automatic vec_t bub(input vec_t x, input logic rdy);
        vec_t y = x;
        y.e_rdy = rdy; y.e_val = 1'b0; y.e_ctrl = 17'd0; y.chk = 1'b0;
        return y;
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        if_valid = v.v; if_inst = v.inst; if_pc = v.pc; ex_stall = v.stall; ex_flush = v.flush;
        wb_regwrite = v.we; wb_rd = v.wrd; wb_wd = v.wd;
        #1;
        chk("id_ready", {31'd0, id_ready}, {31'd0, v.e_rdy});
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.e_val});
        chk("ex_ctrl", {15'd0, ex_ctrl}, {15'd0, e.e_ctrl});
        if (e.chk) begin
            chk("ex_pc",  ex_pc,  e.e_pc);
            chk("ex_rs1", {27'd0, ex_rs1}, {27'd0, e.e_rs1});
            chk("ex_rs2", {27'd0, ex_rs2}, {27'd0, e.e_rs2});
            chk("ex_rd",  {27'd0, ex_rd},  {27'd0, e.e_rd});
            chk("ex_rd1", ex_rd1, e.e_rd1);
            chk("ex_rd2", ex_rd2, e.e_rd2);
            chk("ex_imm", ex_imm, e.e_imm);
        end
    endtask

    initial begin
        vec_t v, s;
        logic [4:0] ri;

        // reset held with a live load on the input
        reset = 1'b0; if_valid = 1'b1; if_inst = 32'h0002A383; if_pc = 32'h40;
        ex_stall = 1'b0; ex_flush = 1'b0; wb_regwrite = 1'b0; wb_rd = 5'd0; wb_wd = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ctrl", {15'd0, ex_ctrl}, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_rd1", ex_rd1, 32'd0);
        chk("rst_imm", ex_imm, 32'd0);
        @(negedge clk);
        reset = 1'b1; if_valid = 1'b0;
        #1;
        chk("rst_id_ready", {31'd0, id_ready}, 32'd1);

        // every register reads zero after reset: add x0,xi,xi
        for (int i = 1; i < 32; i++) begin
            ri = 5'(i);
            v = iv({7'd0, ri, ri, 3'd0, 5'd0, 7'h33}, ri, ri, 5'd0, 32'h0, 32'h0, 32'h0, 17'h10600);
            apply(v);
        end

        v = bub(iv(32'h00000013, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), 1'b1);
        v.v = 1'b0; v.we = 1'b1; v.wrd = 5'd5; v.wd = 32'h1234;
        tbl.push_back(v);
        v = iv(32'hFFF28313, 5'd5, 5'd31, 5'd6, 32'h1234, 32'h0, 32'hFFFFFFFF, 17'h10608);
        v.we = 1'b1; v.wrd = 5'd6; v.wd = 32'h55;
        tbl.push_back(v);
        tbl.push_back(iv(32'h0002A383, 5'd5, 5'd0, 5'd7, 32'h1234, 32'h0, 32'h0, 17'h14688));
        tbl.push_back(bub(iv(32'h00638433, 5'd7, 5'd6, 5'd8, 0, 0, 0, 0), 1'b0));
        tbl.push_back(iv(32'h00638433, 5'd7, 5'd6, 5'd8, 32'h0, 32'h55, 32'h0, 17'h10600));
        tbl.push_back(iv(32'h0002A003, 5'd5, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0, 17'h14688));
        tbl.push_back(iv(32'h00600433, 5'd0, 5'd6, 5'd8, 32'h0, 32'h55, 32'h0, 17'h10600));
        tbl.push_back(iv(32'h0062A423, 5'd5, 5'd6, 5'd8, 32'h1234, 32'h55, 32'h8, 17'h08608));
        tbl.push_back(iv(32'h123451B7, 5'd8, 5'd3, 5'd3, 32'h0, 32'h0, 32'h12345000, 17'h10208));
        tbl.push_back(iv(32'hFE208CE3, 5'd1, 5'd2, 5'd25, 32'h0, 32'h0, 32'hFFFFFFF8, 17'h01A10));
        tbl.push_back(iv(32'h010000EF, 5'd0, 5'd16, 5'd1, 32'h0, 32'h0, 32'h10, 17'h10120));
        tbl.push_back(iv(32'h403100B3, 5'd2, 5'd3, 5'd1, 32'h0, 32'h0, 32'h0, 17'h10800));
        tbl.push_back(iv(32'h4032D213, 5'd5, 5'd3, 5'd4, 32'h1234, 32'h0, 32'h3, 17'h11408));
        v = bub(iv(32'h00638433, 0, 0, 0, 0, 0, 0, 0), 1'b1); v.v = 1'b0;
        tbl.push_back(v);
        v = iv(32'h00048533, 5'd9, 5'd0, 5'd10, BYP_X9, 32'h0, 32'h0, 17'h10600);
        v.we = 1'b1; v.wrd = 5'd9; v.wd = 32'hCAFE;
        tbl.push_back(v);
        tbl.push_back(iv(32'h00048533, 5'd9, 5'd0, 5'd10, 32'hCAFE, 32'h0, 32'h0, 17'h10600));
        v = iv(32'h00000533, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h0, 17'h10600);
        v.we = 1'b1; v.wrd = 5'd0; v.wd = 32'hDEAD;
        tbl.push_back(v);
        tbl.push_back(iv(32'h00000533, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h0, 17'h10600));

        foreach (tbl[i]) begin
            tbl[i].pc   = 32'h1000 + 32'(i) * 32'd4;
            tbl[i].e_pc = tbl[i].pc;
            apply(tbl[i]);
        end

        // two stall cycles with a load-use pending, then flush on top of stall
        v = iv(32'h0002A383, 5'd5, 5'd0, 5'd7, 32'h1234, 32'h0, 32'h0, 17'h14688);
        v.pc = 32'h2000; v.e_pc = 32'h2000;
        apply(v);
        s = v; s.inst = 32'h00638433; s.pc = 32'h2004; s.stall = 1'b1; s.e_rdy = 1'b0;
        apply(s);
        apply(s);
        s.flush = 1'b1;
        apply(bub(s, 1'b1));
        v = iv(32'h00600433, 0, 0, 0, 0, 0, 0, 0); v.flush = 1'b1;
        apply(bub(v, 1'b1));

        // async reset while a load-use hazard is holding ID
        v = iv(32'h0002A383, 5'd5, 5'd0, 5'd7, 32'h1234, 32'h0, 32'h0, 17'h14688);
        v.pc = 32'h3000; v.e_pc = 32'h3000;
        apply(v);
        @(negedge clk);
        if_valid = 1'b1; if_inst = 32'h00638433; if_pc = 32'h3004;
        #1;
        chk("luh_ready", {31'd0, id_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("mid_rst_ctrl", {15'd0, ex_ctrl}, 32'd0);
        chk("mid_rst_rd1", ex_rd1, 32'd0);
        chk("mid_rst_ready", {31'd0, id_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1; if_valid = 1'b0;
        v = iv(32'h00528033, 5'd5, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 17'h10600);
        v.pc = 32'h3008; v.e_pc = 32'h3008;
        apply(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
